// File: rtl/dmem_responder.sv
// Y86 data-memory responder: one 64-bit big-endian read/write per request,
// moved one byte per cycle over 8 beats against a byte-wide RAM.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_we/req_addr/
// req_wdata request side; rsp_valid/rsp_ready/rsp_rdata/rsp_error response
// side; busy is high while a request is in ACCESS or RESP.
module dmem_responder #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic        we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [7:0]  mem [MEM_BYTES];

  logic [ADDR_W:0] end_addr;
  logic            req_err;
  logic [AW-1:0]   byte_addr;
  logic [5:0]      lane;
  logic [7:0]      wbyte;
  logic            accept;

  // One extra bit so an address near the top of the space cannot wrap.
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(7);
  assign req_err   = end_addr > (ADDR_W+1)'(MEM_BYTES - 1);
  assign byte_addr = addr_q + AW'(beat_q);
  // Beat k maps to bits [63-8k -: 8], i.e. lane base 8*(7-k).
  assign lane      = {3'd7 - beat_q, 3'b000};
  assign wbyte     = wdata_q[lane +: 8];
  assign accept    = (state_q == S_IDLE) && req_valid;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // RAM is not reset; reset only blocks further writes.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_ACCESS && we_q) begin
      mem[byte_addr] <= wbyte;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (beat_q == 3'd7) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    beat_d  = beat_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      beat_d  = '0;
      we_d    = req_we;
      addr_d  = req_addr[AW-1:0];
      wdata_d = req_wdata;
      rdata_d = '0;
      error_d = req_err;
    end else if (state_q == S_ACCESS) begin
      beat_d = beat_q + 3'd1;
      if (!we_q) begin
        rdata_d[lane +: 8] = mem[byte_addr];
      end
    end
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    rsp_rdata = rdata_q;
    rsp_error = error_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder.
// Each test task drives its scenario and checks outputs inline.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [4096];

  dmem_responder dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request and collect its response; lat counts edges after accept.
  task automatic issue(input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] rd,
                       output logic er, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 64'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_error !== 1'b0) begin n_bad++;
      $display("FAIL reset_error: got %b want 0", rsp_error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    logic [63:0] rd; logic er; int lat;
    issue(1'b1, 64'h100, 64'h0123456789ABCDEF, rd, er, lat);
    n_cmp++; if (lat !== 8) begin n_bad++;
      $display("FAIL write_latency: got %0d want 8", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++;
      $display("FAIL write_error: got %b want 0", er); end
    n_cmp++; if (rd !== 64'h0) begin n_bad++;
      $display("FAIL write_rdata: got %h want 0", rd); end
  endtask

  task automatic test_read();
    logic [63:0] rd; logic er; int lat;
    issue(1'b0, 64'h100, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_bad++;
      $display("FAIL read_100: got %h want 0123456789abcdef", rd); end
    n_cmp++; if (lat !== 8 || er !== 1'b0) begin n_bad++;
      $display("FAIL read_100_lat: got lat %0d err %b want 8 0", lat, er); end
    issue(1'b1, 64'h108, 64'h1111111111111111, rd, er, lat);
    issue(1'b0, 64'h101, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h23456789ABCDEF11) begin n_bad++;
      $display("FAIL read_101: got %h want 23456789abcdef11", rd); end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat;
    issue(1'b1, 64'hFF8, 64'h0102030405060708, rd, er, lat);
    issue(1'b0, 64'hFF8, 64'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b0 || rd !== 64'h0102030405060708) begin n_bad++;
      $display("FAIL read_ff8: got err %b data %h want 0 0102030405060708",
               er, rd); end
    issue(1'b1, 64'hFF9, 64'hDEADBEEFDEADBEEF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++;
      $display("FAIL write_ff9_err: got %b want 1", er); end
    n_cmp++; if (lat !== 0) begin n_bad++;
      $display("FAIL write_ff9_lat: got %0d want 0", lat); end
    issue(1'b0, 64'hFF8, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h0102030405060708) begin n_bad++;
      $display("FAIL ff9_untouched: got %h want 0102030405060708", rd); end
    issue(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 64'h0) begin n_bad++;
      $display("FAIL read_wrap: got err %b data %h want 1 0", er, rd); end
    n_cmp++; if (lat !== 0) begin n_bad++;
      $display("FAIL read_wrap_lat: got %0d want 0", lat); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat;
    req_we = 1'b0; req_addr = 64'h100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++;
      $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
    // Competing write must be ignored while the response is pending.
    req_we = 1'b1; req_addr = 64'h100; req_wdata = 64'h5555555555555555;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0123456789ABCDEF ||
          rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v%b d%h e%b r%b want v1 d0123456789abcdef e0 r0",
                 i, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++;
      $display("FAIL bp_release: got ready %b valid %b want 1 0",
               req_ready, rsp_valid); end
    req_we = 1'b0; req_addr = 64'h108; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL bp_next_accept: got busy %b want 1", busy); end
    repeat (8) begin @(posedge clk); #1; end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h1111111111111111) begin
      n_bad++;
      $display("FAIL bp_next_rsp: got v%b d%h want v1 d1111111111111111",
               rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 64'h100, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_bad++;
      $display("FAIL bp_ignored_write: got %h want 0123456789abcdef", rd); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rd; logic er; int lat; int seen;
    issue(1'b1, 64'h200, 64'h0, rd, er, lat);
    req_we = 1'b1; req_addr = 64'h200; req_wdata = 64'hAABBCCDDEEFF0011;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++;
      $display("FAIL abort_state: got ready %b valid %b want 1 0",
               req_ready, rsp_valid); end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++;
      $display("FAIL abort_no_rsp: got %0d valid cycles want 0", seen); end
    issue(1'b0, 64'h200, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'hAABBCCDD00000000) begin n_bad++;
      $display("FAIL abort_mem: got %h want aabbccdd00000000", rd); end
  endtask

  task automatic test_random();
    logic [63:0] rd, wd, exp, a; logic er; int lat; logic we;
    for (int i = 0; i < 32; i++) begin
      wd = {$urandom(), $urandom()};
      a = 64'h400 + 64'(i * 8);
      issue(1'b1, a, wd, rd, er, lat);
      for (int k = 0; k < 8; k++) model[a + 64'(k)] = wd[63 - 8*k -: 8];
    end
    for (int i = 0; i < 20; i++) begin
      we = ($urandom_range(0, 1) == 1);
      a = 64'($urandom_range(12'h400, 12'h4F8));
      wd = {$urandom(), $urandom()};
      exp = 64'h0;
      if (!we)
        for (int k = 0; k < 8; k++) exp[63 - 8*k -: 8] = model[a + 64'(k)];
      issue(we, a, wd, rd, er, lat);
      if (we)
        for (int k = 0; k < 8; k++) model[a + 64'(k)] = wd[63 - 8*k -: 8];
      n_cmp++;
      if (rd !== exp || er !== 1'b0 || lat !== 8) begin
        n_bad++;
        $display("FAIL rand%0d we%b a%h: got d%h e%b lat%0d want d%h e0 lat8",
                 i, we, a, rd, er, lat, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_range();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
